spi_reg_bridge: RTL and testbench
=================================

// Module: spi_reg_bridge
// PURPOSE
//  SPI slave that turns MCU command frames into transactions on the internal ArcDVI
//  register bus (VIDC register mirror at 0x000, video output regs at 0x800...).
//  It sits between the soc_top_arcdvi SPI pins and the register-bus decoder.
//  SPI pins are asynchronous to clk; all logic is clocked on clk.
// PARAMETERS
//  ADDR_W       12   register address width
//  DATA_W       32   register data width
//  SYNC_STAGES  2    synchroniser depth on spi_clk/spi_ncs/spi_din (>=2)
// PORTS
//  clk          in   1       system clock; spi_clk period must be >= 4 clk
//  nreset       in   1       asynchronous, active-low reset
//  spi_clk      in   1       SPI clock, mode 0
//  spi_ncs      in   1       SPI chip select, active low
//  spi_din      in   1       MOSI
//  spi_dout     out  1       MISO
//  reg_addr     out  ADDR_W  register address, held stable while req/wr is active
//  reg_wdata    out  DATA_W  write data
//  reg_wr       out  1       one-clk write strobe
//  reg_rd_req   out  1       read request, held until reg_rd_ack
//  reg_rd_ack   in   1       read complete; reg_rdata is valid in the same cycle
//  reg_rdata    in   DATA_W  read data
//  rd_err       out  1       sticky: a read timed out; cleared by a successful read
// BEHAVIOUR
//  Reset: spi_dout=0, reg_wr=0, reg_rd_req=0, reg_addr=0, reg_wdata=0, rd_err=0, FSM=IDLE.
//  Frame (MSB first, 48 bits): cmd[1:0] (00 read, 01 write, 1x reserved), addr[11:0], pad[1:0], data[31:0].
//  Pins pass through SYNC_STAGES flops, then edge detection: din sampled on sclk rise, dout updated on sclk rise-detect.
//  FSM IDLE -> CMD on ncs fall. CMD shifts 16 bits; bit count 0..47.
//   After bit 13: latch addr. If cmd=00, assert reg_rd_req (-> RDWAIT).
//   RDWAIT: on reg_rd_ack, load reg_rdata into tx shift reg, drop req the next clk.
//   After the rise-detect of bit 15, spi_dout = tx[31]; each later rise-detect shifts by one.
//   If no ack by then: drop req, tx = 32'hFFFF_FFFF, set rd_err.
//   DATA: bits 16..47 shift into the rx reg. After bit 47, cmd=01 -> reg_addr/reg_wdata
//   updated and reg_wr pulses for exactly 1 clk, 2 clks after the bit-47 rise-detect.
//  Reserved cmd: no bus activity, dout=0, data bits discarded.
//  ncs rise at any point: abort to IDLE. Drop reg_rd_req if it is pending. No write, dout=0.
//   A late ack is ignored.
//  ncs high or CMD phase: spi_dout=0. Bits beyond 48 (no burst): ignored, dout=0.
//  reg_wr and reg_rd_req are never active in the same cycle. At most one bus op is outstanding.
//  nreset mid-frame: immediate return to reset state. The frame in progress is dropped until the next ncs fall.
// CONFIGURATION
//  SPI_BURST_EN defined: after bit 47, each further 32 bits is another transfer at addr+1.
//   Addr wraps modulo 2^ADDR_W. Reads prefetch addr+1 at bit 47 of the current word, with the same
//   timeout rule at the next word boundary. Writes strobe per complete word. A partial word is discarded.
//  Not defined: one transfer per frame, as above.
// STRUCTURE
//  Package arcdvi_spi_pkg: CMD_RD/CMD_WR codes, FRAME_BITS=48, HDR_BITS=16, ADDR_LAST_BIT=13,
//   RD_TIMEOUT_DATA=32'hFFFF_FFFF, FSM state enum {IDLE,CMD,RDWAIT,DATA}.
//  Sub-module spi_sync_edge: N-stage synchroniser plus rise/fall pulse outputs.
//   Instantiated for sclk and ncs; din uses the sync only.
// TESTING
//  1 Write 0x808 <= 0x00000001 (SCLK half-period 50ns, clk 20ns) -> a single reg_wr,
//    reg_addr=0x808, reg_wdata=0x1; MISO all 0.
//  2 Read 0x014, bus model acks 1 clk after req with 0x005A5A5A -> rx[31:0]=0x005A5A5A, rd_err=0.
//  3 Read 0x015, bus never acks -> rx[31:0]=0xFFFFFFFF, rd_err=1, req dropped.
//    A subsequent good read of 0x000 clears rd_err.
//  4 Write frame aborted by ncs rise after 20 bits -> no reg_wr. The next full write of
//    0x001 <= 0x111 succeeds.
//  5 nreset pulsed at bit 30 of a read -> all outputs at reset values. The next frame decodes correctly.
//  6 (SPI_BURST_EN) 112-bit write frame at 0xFFF with words A,B,C -> three reg_wr at 0xFFF, 0x000, 0x001.

Source files
------------

// File: rtl/arcdvi_spi_pkg.sv
// Shared constants and the FSM state type for the SPI to register-bus bridge.
// Holds the command codes and frame geometry, so the top and the bench agree on bit positions.
package arcdvi_spi_pkg;

   localparam logic [1:0]  CMD_RD          = 2'b00;
   localparam logic [1:0]  CMD_WR          = 2'b01;
   localparam int          FRAME_BITS      = 48;
   localparam int          HDR_BITS        = 16;
   localparam int          ADDR_LAST_BIT   = 13;
   localparam logic [31:0] RD_TIMEOUT_DATA = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      RDWAIT,
      DATA
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, with one-clk rise/fall pulses.
// RST_VAL sets the value the chain and edge history assume while reset is active.
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic nreset,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave turning 48-bit MCU frames into register-bus reads and writes.
// Define SPI_BURST_EN to let a frame continue with further 32-bit words at incrementing addresses.
//
// state  | meaning
// IDLE   | waiting for chip-select to fall
// CMD    | shifting the 16-bit header (cmd, addr, pad)
// RDWAIT | read request issued, waiting for ack before the header ends
// DATA   | 32-bit data phase: rx shifts in, tx shifts out on MISO
module spi_reg_bridge
   import arcdvi_spi_pkg::*;
#(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              spi_clk,
   input  logic              spi_ncs,
   input  logic              spi_din,
   output logic              spi_dout,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd_req,
   input  logic              reg_rd_ack,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              rd_err
);

   localparam logic [5:0] BIT_ADDR_LAST  = 6'(ADDR_LAST_BIT);
   localparam logic [5:0] BIT_HDR_LAST   = 6'(HDR_BITS - 1);
   localparam logic [5:0] BIT_FRAME_LAST = 6'(FRAME_BITS - 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic ncs_s, ncs_rise, ncs_fall;
   logic [SYNC_STAGES-1:0] din_sync_q;
   logic din_s;

   spi_state_e        state_q, state_d;
   logic [5:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              dout_q, dout_d;
   logic [1:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] rdbuf_q, rdbuf_d;
   logic              rd_ok_q, rd_ok_d;
   logic              rd_err_q, rd_err_d;
   logic              fetch_pend_q, fetch_pend_d;
   logic              wr_pend_q, wr_pend_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              reg_wr_q, reg_wr_d;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;

   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] word;
   logic              word_start;
   logic              ack_now;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk    (clk),
      .nreset (nreset),
      .d_i    (spi_clk),
      .q_o    (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   // ncs resets to the selected level so a frame already in flight at reset
   // release never shows a fall; decoding resumes at the next real ncs fall.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ncs (
      .clk    (clk),
      .nreset (nreset),
      .d_i    (spi_ncs),
      .q_o    (ncs_s),
      .rise_o (ncs_rise),
      .fall_o (ncs_fall)
   );

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) din_sync_q <= '0;
      else         din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
   end
   assign din_s = din_sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      dout_d       = dout_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      req_d        = req_q;
      rdbuf_d      = rdbuf_q;
      rd_ok_d      = rd_ok_q;
      rd_err_d     = rd_err_q;
      fetch_pend_d = 1'b0;
      wr_pend_d    = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      reg_wr_d     = wr_pend_q;
      reg_addr_d   = reg_addr_q;
      reg_wdata_d  = reg_wdata_q;
      word         = '0;
      word_start   = 1'b0;
      rx_next      = {rx_q[DATA_W-2:0], din_s};
      ack_now      = req_q & reg_rd_ack;

      if (wr_pend_q) begin
         reg_addr_d  = wr_addr_q;
         reg_wdata_d = wr_data_q;
      end
      if (fetch_pend_q) begin
         req_d      = 1'b1;
         reg_addr_d = addr_q + ADDR_W'(1);
         rd_ok_d    = 1'b0;
      end
      if (ack_now) begin
         rdbuf_d  = reg_rdata;
         rd_ok_d  = 1'b1;
         rd_err_d = 1'b0;
         req_d    = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (ncs_fall) begin
               state_d   = CMD;
               bit_cnt_d = '0;
            end
         end
         default: begin
            if (sclk_rise) begin
               rx_d      = rx_next;
               bit_cnt_d = bit_cnt_q + 6'd1;
               if (bit_cnt_q == BIT_ADDR_LAST) begin
                  cmd_d  = rx_next[ADDR_W+1:ADDR_W];
                  addr_d = rx_next[ADDR_W-1:0];
                  if (rx_next[ADDR_W+1:ADDR_W] == CMD_RD) begin
                     req_d      = 1'b1;
                     reg_addr_d = rx_next[ADDR_W-1:0];
                     rd_ok_d    = 1'b0;
                     state_d    = RDWAIT;
                  end
               end else if (bit_cnt_q == BIT_HDR_LAST) begin
                  word_start = 1'b1;
                  state_d    = DATA;
               end else if (state_q == DATA) begin
                  if (bit_cnt_q == BIT_FRAME_LAST) begin
                     if (cmd_q == CMD_WR) begin
                        wr_pend_d = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_next;
                     end
`ifdef SPI_BURST_EN
                     bit_cnt_d  = BIT_HDR_LAST + 6'd1;
                     addr_d     = addr_q + ADDR_W'(1);
                     word_start = 1'b1;
`else
                     state_d = IDLE;
                     dout_d  = 1'b0;
                     tx_d    = '0;
`endif
                  end else begin
                     dout_d = tx_q[DATA_W-1];
                     tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                  end
               end
            end
         end
      endcase

      // Word boundary: the MISO word is whatever the bus returned by now, else the timeout pattern.
      if (word_start) begin
         if (cmd_q == CMD_RD) begin
            if (ack_now) begin
               word = reg_rdata;
            end else if (rd_ok_q) begin
               word = rdbuf_q;
            end else begin
               word     = DATA_W'(RD_TIMEOUT_DATA);
               rd_err_d = 1'b1;
               req_d    = 1'b0;
            end
            rd_ok_d = 1'b0;
`ifdef SPI_BURST_EN
            fetch_pend_d = 1'b1;
`endif
         end
         dout_d = word[DATA_W-1];
         tx_d   = {word[DATA_W-2:0], 1'b0};
      end

      if (ncs_rise) begin
         state_d      = IDLE;
         req_d        = 1'b0;
         fetch_pend_d = 1'b0;
         wr_pend_d    = 1'b0;
         dout_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         dout_q       <= 1'b0;
         cmd_q        <= '0;
         addr_q       <= '0;
         req_q        <= 1'b0;
         rdbuf_q      <= '0;
         rd_ok_q      <= 1'b0;
         rd_err_q     <= 1'b0;
         fetch_pend_q <= 1'b0;
         wr_pend_q    <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         reg_wr_q     <= 1'b0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         dout_q       <= dout_d;
         cmd_q        <= cmd_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         rdbuf_q      <= rdbuf_d;
         rd_ok_q      <= rd_ok_d;
         rd_err_q     <= rd_err_d;
         fetch_pend_q <= fetch_pend_d;
         wr_pend_q    <= wr_pend_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         reg_wr_q     <= reg_wr_d;
         reg_addr_q   <= reg_addr_d;
         reg_wdata_q  <= reg_wdata_d;
      end
   end

   assign spi_dout   = dout_q;
   assign reg_addr   = reg_addr_q;
   assign reg_wdata  = reg_wdata_q;
   assign reg_wr     = reg_wr_q;
   assign reg_rd_req = req_q;
   assign rd_err     = rd_err_q;

   logic unused_ok;
   assign unused_ok = ^{sclk_s, sclk_fall, ncs_s, rx_q[DATA_W-1]};

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge; build with SPI_BURST_EN to add the burst case.
module tb_spi_reg_bridge;

   logic        clk = 1'b0;
   logic        nreset;
   logic        spi_clk, spi_ncs, spi_din, spi_dout;
   logic [11:0] reg_addr;
   logic [31:0] reg_wdata;
   logic        reg_wr, reg_rd_req;
   logic        reg_rd_ack = 1'b0;
   logic [31:0] reg_rdata;
   logic        rd_err;

   int checks   = 0;
   int failures = 0;

   logic        ack_en;
   int          ack_cnt = 0;
   logic [11:0] ack_addr [0:31];
   int          wr_cnt = 0;
   logic [11:0] wr_addr_log [0:15];
   logic [31:0] wr_data_log [0:15];
   int          overlap = 0;

   always #10 clk = ~clk;

   spi_reg_bridge dut (
      .clk        (clk),
      .nreset     (nreset),
      .spi_clk    (spi_clk),
      .spi_ncs    (spi_ncs),
      .spi_din    (spi_din),
      .spi_dout   (spi_dout),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_wr     (reg_wr),
      .reg_rd_req (reg_rd_req),
      .reg_rd_ack (reg_rd_ack),
      .reg_rdata  (reg_rdata),
      .rd_err     (rd_err)
   );

   // Bus model: one-clk ack, one clk after the request is seen.
   always @(posedge clk) begin
      reg_rd_ack <= 1'b0;
      if (ack_en && reg_rd_req && !reg_rd_ack) begin
         reg_rd_ack <= 1'b1;
         if (ack_cnt < 32) ack_addr[ack_cnt] <= reg_addr;
         ack_cnt <= ack_cnt + 1;
      end
   end

   always @(posedge clk) begin
      if (reg_wr) begin
         if (wr_cnt < 16) begin
            wr_addr_log[wr_cnt] = reg_addr;
            wr_data_log[wr_cnt] = reg_wdata;
         end
         wr_cnt = wr_cnt + 1;
      end
      if (reg_wr && reg_rd_req) overlap = overlap + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] hdr(input logic [1:0] cmd, input logic [11:0] addr);
      return {cmd, addr, 2'b00};
   endfunction

   // Frame is left-aligned in 112 bits; MISO is sampled just before each rising edge.
   task automatic spi_xfer(input logic [111:0] frame, input int nbits, input int rst_at,
                           output logic [111:0] miso);
      miso    = '0;
      spi_ncs = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         spi_din = frame[111-i];
         if (i == rst_at) begin
            nreset = 1'b0;
            #30;
            nreset = 1'b1;
         end
         #50;
         miso[111-i] = spi_dout;
         spi_clk = 1'b1;
         #50;
         spi_clk = 1'b0;
      end
      #50;
      spi_ncs = 1'b1;
      spi_din = 1'b0;
      #200;
   endtask

   logic [111:0] m;
   int           ack0;

   initial begin
      nreset    = 1'b0;
      spi_clk   = 1'b0;
      spi_ncs   = 1'b1;
      spi_din   = 1'b0;
      ack_en    = 1'b0;
      reg_rdata = 32'h0;
      #45;
      check("rst_dout", 64'(spi_dout), 64'h0);
      check("rst_wr", 64'(reg_wr), 64'h0);
      check("rst_req", 64'(reg_rd_req), 64'h0);
      check("rst_addr", 64'(reg_addr), 64'h0);
      check("rst_wdata", 64'(reg_wdata), 64'h0);
      check("rst_err", 64'(rd_err), 64'h0);
      #20 nreset = 1'b1;
      #200;

      // 1: single write
      spi_xfer({hdr(2'b01, 12'h808), 32'h0000_0001, 64'h0}, 48, -1, m);
      check("t1_wr_cnt", 64'(wr_cnt), 64'd1);
      check("t1_wr_addr", 64'(wr_addr_log[0]), 64'h808);
      check("t1_wr_data", 64'(wr_data_log[0]), 64'h1);
      check("t1_miso", 64'(m[111:64]), 64'h0);
      check("t1_wr_low", 64'(reg_wr), 64'h0);

      // 2: acked read
      ack_en    = 1'b1;
      reg_rdata = 32'h005A_5A5A;
      ack0      = ack_cnt;
      spi_xfer({hdr(2'b00, 12'h014), 32'h0, 64'h0}, 48, -1, m);
      check("t2_rx", 64'(m[95:64]), 64'h005A_5A5A);
      check("t2_err", 64'(rd_err), 64'h0);
      check("t2_ack_addr", 64'(ack_addr[ack0]), 64'h014);
      check("t2_req_low", 64'(reg_rd_req), 64'h0);

      // 3: timed-out read, then a good read clears rd_err
      ack_en = 1'b0;
      spi_xfer({hdr(2'b00, 12'h015), 32'h0, 64'h0}, 48, -1, m);
      check("t3_rx", 64'(m[95:64]), 64'hFFFF_FFFF);
      check("t3_err", 64'(rd_err), 64'h1);
      check("t3_req_low", 64'(reg_rd_req), 64'h0);
      ack_en    = 1'b1;
      reg_rdata = 32'h1234_5678;
      spi_xfer({hdr(2'b00, 12'h000), 32'h0, 64'h0}, 48, -1, m);
      check("t3_rx2", 64'(m[95:64]), 64'h1234_5678);
      check("t3_err_clr", 64'(rd_err), 64'h0);

      // 4: aborted write, then a complete one
      spi_xfer({hdr(2'b01, 12'h001), 32'h0000_0111, 64'h0}, 20, -1, m);
      check("t4_abort_cnt", 64'(wr_cnt), 64'd1);
      spi_xfer({hdr(2'b01, 12'h001), 32'h0000_0111, 64'h0}, 48, -1, m);
      check("t4_wr_cnt", 64'(wr_cnt), 64'd2);
      check("t4_wr_addr", 64'(wr_addr_log[1]), 64'h001);
      check("t4_wr_data", 64'(wr_data_log[1]), 64'h111);

      // 5: reset mid-read (timed-out read so rd_err is set before the reset)
      ack_en = 1'b0;
      spi_xfer({hdr(2'b00, 12'h015), 32'h0, 64'h0}, 48, 30, m);
      check("t5_pre_rst_rx", 64'(m[95:82]), 64'h3FFF);
      check("t5_post_rst_rx", 64'(m[81:64]), 64'h0);
      check("t5_err", 64'(rd_err), 64'h0);
      check("t5_addr", 64'(reg_addr), 64'h0);
      check("t5_req", 64'(reg_rd_req), 64'h0);
      check("t5_dout", 64'(spi_dout), 64'h0);
      check("t5_wr_cnt", 64'(wr_cnt), 64'd2);
      spi_xfer({hdr(2'b01, 12'h0AB), 32'hCAFE_F00D, 64'h0}, 48, -1, m);
      check("t5_wr_cnt2", 64'(wr_cnt), 64'd3);
      check("t5_wr_addr", 64'(wr_addr_log[2]), 64'h0AB);
      check("t5_wr_data", 64'(wr_data_log[2]), 64'hCAFE_F00D);
      ack_en    = 1'b1;
      reg_rdata = 32'h8000_0001;
      spi_xfer({hdr(2'b00, 12'h014), 32'h0, 64'h0}, 48, -1, m);
      check("t5_rx", 64'(m[95:64]), 64'h8000_0001);

      // Reserved command: no bus activity, MISO silent
      ack0 = ack_cnt;
      spi_xfer({hdr(2'b10, 12'h055), 32'hFFFF_FFFF, 64'h0}, 48, -1, m);
      check("rsv_wr_cnt", 64'(wr_cnt), 64'd3);
      check("rsv_ack_cnt", 64'(ack_cnt), 64'(ack0));
      check("rsv_miso", 64'(m[111:64]), 64'h0);

      // Trailing partial word: exactly one write either way, MISO silent
      spi_xfer({hdr(2'b01, 12'h123), 32'hA5A5_0F0F, 8'hFF, 56'h0}, 56, -1, m);
      check("tail_wr_cnt", 64'(wr_cnt), 64'd4);
      check("tail_wr_addr", 64'(wr_addr_log[3]), 64'h123);
      check("tail_wr_data", 64'(wr_data_log[3]), 64'hA5A5_0F0F);
      check("tail_miso", 64'(m[111:56]), 64'h0);

`ifdef SPI_BURST_EN
      // 6: burst write wrapping through the top of the address space
      spi_xfer({hdr(2'b01, 12'hFFF), 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}, 112, -1, m);
      check("t6_wr_cnt", 64'(wr_cnt), 64'd7);
      check("t6_addr0", 64'(wr_addr_log[4]), 64'hFFF);
      check("t6_addr1", 64'(wr_addr_log[5]), 64'h000);
      check("t6_addr2", 64'(wr_addr_log[6]), 64'h001);
      check("t6_data0", 64'(wr_data_log[4]), 64'hAAAA_0001);
      check("t6_data1", 64'(wr_data_log[5]), 64'hBBBB_0002);
      check("t6_data2", 64'(wr_data_log[6]), 64'hCCCC_0003);
`endif

      check("no_overlap", 64'(overlap), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
